// File: rtl/uart_tx_inbuf.sv
// Transmit input buffer for the UART-Tx path: a DEPTH-entry FIFO feeding a holding register for the PISO.
// Optional sticky overflow flag with clear input, enabled by defining UART_INBUF_OVF_FLAG_EN.
module uart_tx_inbuf #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 4,
  localparam int ADDR_W    = $clog2(DEPTH)
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  input  logic                  done_flag,
  output logic [DATA_WIDTH-1:0] reg_data,
  output logic                  reg_valid,
  output logic [ADDR_W:0]       fifo_count
`ifdef UART_INBUF_OVF_FLAG_EN
  ,
  output logic                  ovf_flag,
  input  logic                  ovf_clr
`endif
);

  logic [ADDR_W:0]       wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [DATA_WIDTH-1:0] mem_d [DEPTH];
  logic [DATA_WIDTH-1:0] reg_data_q, reg_data_d;
  logic                  reg_valid_q, reg_valid_d;

  logic empty, full, do_write, do_load, do_drain;

  // Extra pointer MSB distinguishes full from empty when the index bits match.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[ADDR_W] != rd_ptr_q[ADDR_W]) &&
                 (wr_ptr_q[ADDR_W-1:0] == rd_ptr_q[ADDR_W-1:0]);

  assign do_write = data_valid && !full;
  assign do_load  = !empty && (!reg_valid_q || done_flag);
  assign do_drain = done_flag && empty && reg_valid_q;

  assign data_ready = !full;
  assign reg_data   = reg_data_q;
  assign reg_valid  = reg_valid_q;
  assign fifo_count = wr_ptr_q - rd_ptr_q;

  always_comb begin
    // NOTE: every signal gets a default before any branch, so no latches are inferred.
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    mem_d       = mem_q;
    reg_data_d  = reg_data_q;
    reg_valid_d = reg_valid_q;

    if (do_write) begin
      mem_d[wr_ptr_q[ADDR_W-1:0]] = data_in;
      wr_ptr_d                    = wr_ptr_q + 1'b1;
    end

    if (do_load) begin
      reg_data_d  = mem_q[rd_ptr_q[ADDR_W-1:0]];
      reg_valid_d = 1'b1;
      rd_ptr_d    = rd_ptr_q + 1'b1;
    end else if (do_drain) begin
      reg_data_d  = '1;
      reg_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      reg_data_q  <= '1;
      reg_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      reg_data_q  <= reg_data_d;
      reg_valid_q <= reg_valid_d;
    end
  end

  // NOTE: storage is left unreset; equal pointers mark it empty, so stale contents are never read.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

`ifdef UART_INBUF_OVF_FLAG_EN
  logic ovf_q, ovf_d;

  // Set is evaluated last so it wins over a simultaneous clear.
  always_comb begin
    ovf_d = ovf_q;
    if (ovf_clr) ovf_d = 1'b0;
    if (data_valid && full) ovf_d = 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) ovf_q <= 1'b0;
    else          ovf_q <= ovf_d;
  end

  assign ovf_flag = ovf_q;
`endif

endmodule

// File: tb/tb_uart_tx_inbuf.sv
// Directed self-checking bench for uart_tx_inbuf (DATA_WIDTH = 8, DEPTH = 4).
// Overflow-flag checks are compiled in when UART_INBUF_OVF_FLAG_EN is defined.
module tb_uart_tx_inbuf;

  logic       clock = 1'b0;
  logic       reset_n;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       done_flag;
  logic [7:0] reg_data;
  logic       reg_valid;
  logic [2:0] fifo_count;
`ifdef UART_INBUF_OVF_FLAG_EN
  logic       ovf_flag;
  logic       ovf_clr;
`endif

  int checks = 0;
  int errors = 0;

  uart_tx_inbuf #(.DATA_WIDTH(8), .DEPTH(4)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .data_in    (data_in),
    .data_valid (data_valid),
    .data_ready (data_ready),
    .done_flag  (done_flag),
    .reg_data   (reg_data),
    .reg_valid  (reg_valid),
    .fifo_count (fifo_count)
`ifdef UART_INBUF_OVF_FLAG_EN
    ,
    .ovf_flag   (ovf_flag),
    .ovf_clr    (ovf_clr)
`endif
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_reset();
    reset_n    = 1'b0;
    data_valid = 1'b0;
    done_flag  = 1'b0;
    data_in    = 8'h00;
`ifdef UART_INBUF_OVF_FLAG_EN
    ovf_clr    = 1'b0;
`endif
    tick();
    reset_n = 1'b1;
  endtask

  task automatic check_state(input string name, input logic [7:0] exp_data,
                             input logic exp_valid, input logic [2:0] exp_count,
                             input logic exp_ready);
    checks++;
    if (reg_data !== exp_data || reg_valid !== exp_valid ||
        fifo_count !== exp_count || data_ready !== exp_ready) begin
      errors++;
      $display("FAIL %s: got data=%h valid=%b count=%0d ready=%b, want data=%h valid=%b count=%0d ready=%b",
               name, reg_data, reg_valid, fifo_count, data_ready,
               exp_data, exp_valid, exp_count, exp_ready);
    end
  endtask

  task automatic test_reset();
    apply_reset();
    check_state("reset", 8'hFF, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_single();
    apply_reset();
    data_in = 8'hA5; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_state("single_accept_edge", 8'hFF, 1'b0, 3'd1, 1'b1);
    tick();
    check_state("single_latency", 8'hA5, 1'b1, 3'd0, 1'b1);
    tick();
    check_state("single_held", 8'hA5, 1'b1, 3'd0, 1'b1);
  endtask

  task automatic test_fill();
    logic [7:0] words [5];
    words = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      data_in = words[i]; data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check_state("fill_full", 8'h11, 1'b1, 3'd4, 1'b0);
    data_in = 8'h66; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    check_state("fill_refused", 8'h11, 1'b1, 3'd4, 1'b0);
`ifdef UART_INBUF_OVF_FLAG_EN
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_set: got %b want 1", ovf_flag);
    end
    ovf_clr = 1'b1; data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    checks++;
    if (ovf_flag !== 1'b1) begin
      errors++; $display("FAIL ovf_set_wins: got %b want 1", ovf_flag);
    end
    tick();
    ovf_clr = 1'b0;
    checks++;
    if (ovf_flag !== 1'b0) begin
      errors++; $display("FAIL ovf_clear: got %b want 0", ovf_flag);
    end
`endif
  endtask

  // Continues from the full state left by test_fill.
  task automatic test_drain();
    logic [7:0] exp_data [5];
    logic [2:0] exp_count [5];
    exp_data  = '{8'h22, 8'h33, 8'h44, 8'h55, 8'hFF};
    exp_count = '{3'd3, 3'd2, 3'd1, 3'd0, 3'd0};
    for (int i = 0; i < 5; i++) begin
      done_flag = 1'b1;
      tick();
      done_flag = 1'b0;
      check_state($sformatf("drain_pulse%0d", i), exp_data[i], (i < 4), exp_count[i], 1'b1);
      tick();
      tick();
      check_state($sformatf("drain_stable%0d", i), exp_data[i], (i < 4), exp_count[i], 1'b1);
    end
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
    check_state("done_when_idle", 8'hFF, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    for (int i = 1; i <= 3; i++) begin
      data_in = 8'(i); data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check_state("simul_pre", 8'h01, 1'b1, 3'd2, 1'b1);
    data_in = 8'h04; data_valid = 1'b1; done_flag = 1'b1;
    tick();
    data_valid = 1'b0; done_flag = 1'b0;
    check_state("simul_write_load", 8'h02, 1'b1, 3'd2, 1'b1);
    done_flag = 1'b1;
    tick();
    check_state("simul_next", 8'h03, 1'b1, 3'd1, 1'b1);
    tick();
    done_flag = 1'b0;
    check_state("simul_tail", 8'h04, 1'b1, 3'd0, 1'b1);
  endtask

  task automatic test_stream();
    int  next_wr = 0;
    int  exp_idx = 0;
    int  gap     = 0;
    int  cycles  = 0;
    logic prev_valid, sent_done;
    apply_reset();
    while (exp_idx < 10 && cycles < 400) begin
      data_valid = (next_wr < 10);
      data_in    = 8'(next_wr);
      if (reg_valid && gap == 0) begin
        done_flag = 1'b1;
        gap       = int'($urandom_range(0, 3));
      end else begin
        done_flag = 1'b0;
        if (gap > 0) gap--;
      end
      prev_valid = reg_valid;
      sent_done  = done_flag;
      if (data_valid && data_ready) next_wr++;
      tick();
      cycles++;
      if (reg_valid && (!prev_valid || sent_done)) begin
        checks++;
        if (reg_data !== 8'(exp_idx)) begin
          errors++;
          $display("FAIL stream_order: got %h want %h", reg_data, 8'(exp_idx));
        end
        exp_idx++;
      end
    end
    data_valid = 1'b0;
    done_flag  = 1'b0;
    checks++;
    if (exp_idx != 10) begin
      errors++;
      $display("FAIL stream_timeout: got %0d words want 10", exp_idx);
    end
    done_flag = 1'b1;
    tick();
    done_flag = 1'b0;
    check_state("stream_drained", 8'hFF, 1'b0, 3'd0, 1'b1);
  endtask

  task automatic test_reset_mid();
    apply_reset();
    for (int i = 0; i < 4; i++) begin
      data_in = 8'h70 + 8'(i); data_valid = 1'b1;
      tick();
    end
    data_valid = 1'b0;
    check_state("mid_pre", 8'h70, 1'b1, 3'd3, 1'b1);
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    check_state("mid_reset", 8'hFF, 1'b0, 3'd0, 1'b1);
    tick();
    check_state("mid_after", 8'hFF, 1'b0, 3'd0, 1'b1);
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_drain();
    test_simultaneous();
    test_stream();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
